// File: rtl/mul_operand_feeder.sv
// mul_operand_feeder
//   Queues operand pairs from a valid/ready producer and issues them one at a
//   time to a sequential multiplier. For each pair it drives OpA/OpB, holds
//   start high for START_LEN cycles, then waits for mul_done before issuing
//   the next pair. Pairs can issue back to back with no idle cycle between them.
//
//   Optional feature macro: MUL_FEED_TIMEOUT_EN
//     When defined, a watchdog runs in WAIT. If TIMEOUT cycles pass without
//     mul_done, the feeder raises the sticky timeout_err flag, drops the
//     in-flight pair and goes back to IDLE. Entries still in the FIFO are
//     then processed as usual.
//     When undefined, the timeout_err port and the watchdog do not exist.
//
//   Handshake: the producer's pair transfers on a rising clk edge where
//   in_valid && in_ready are both high. in_ready depends only on FIFO
//   fullness, never on in_valid. While in_ready is low, in_valid is ignored.
//
//   fsm_state exposes the controller state: 0 = IDLE, 1 = LAUNCH, 2 = WAIT.
module mul_operand_feeder #(
   parameter int width     = 8,
   parameter int DEPTH     = 4,
   parameter int START_LEN = 3
`ifdef MUL_FEED_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 64
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [width-1:0]         in_opa,
   input  logic [width-1:0]         in_opb,
   input  logic                     mul_done,
   output logic                     start,
   output logic [width-1:0]         OpA,
   output logic [width-1:0]         OpB,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
`ifdef MUL_FEED_TIMEOUT_EN
   output logic                     timeout_err,
`endif
   output logic [1:0]               fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(START_LEN + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(START_LEN - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------
   logic [2*width-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [2*width-1:0] head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign level    = wr_ptr - rd_ptr;
   assign head     = mem[rd_ptr[AW-1:0]];

   // Storage array: written on an accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {in_opa, in_opb};
      end
   end

   // Pointer update; reset flushes the queue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Issue controller
   // ---------------------------------------------------------------------
   state_t            state_q;
   state_t            state_n;
   logic              start_n;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_n;
   logic [width-1:0]  opa_n;
   logic [width-1:0]  opb_n;

`ifdef MUL_FEED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   logic [TW-1:0]     tcnt_q;
   logic [TW-1:0]     tcnt_n;
   logic              terr_n;
`endif

   assign busy      = (state_q != IDLE);
   assign fsm_state = state_q;

   // Controller state and registered outputs; reset aborts any launch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         start   <= 1'b0;
         cnt_q   <= '0;
         OpA     <= '0;
         OpB     <= '0;
      end else begin
         state_q <= state_n;
         start   <= start_n;
         cnt_q   <= cnt_n;
         OpA     <= opa_n;
         OpB     <= opb_n;
      end
   end

`ifdef MUL_FEED_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt_q      <= '0;
         timeout_err <= 1'b0;
      end else begin
         tcnt_q      <= tcnt_n;
         timeout_err <= terr_n;
      end
   end
`endif

   // Next-state logic: pop the head and launch whenever a pair is available.
   always_comb begin
      state_n = state_q;
      start_n = start;
      cnt_n   = cnt_q;
      opa_n   = OpA;
      opb_n   = OpB;
      pop     = 1'b0;
`ifdef MUL_FEED_TIMEOUT_EN
      tcnt_n  = tcnt_q;
      terr_n  = timeout_err;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               opa_n   = head[2*width-1:width];
               opb_n   = head[width-1:0];
               start_n = 1'b1;
               cnt_n   = CNT_LOAD;
               state_n = LAUNCH;
            end
         end
         LAUNCH: begin
            // mul_done is deliberately ignored while start is still high.
            if (cnt_q == '0) begin
               start_n = 1'b0;
               state_n = WAIT;
`ifdef MUL_FEED_TIMEOUT_EN
               tcnt_n  = '0;
`endif
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         WAIT: begin
            if (mul_done) begin
               if (!empty) begin
                  // Back-to-back issue: no IDLE cycle between products.
                  pop     = 1'b1;
                  opa_n   = head[2*width-1:width];
                  opb_n   = head[width-1:0];
                  start_n = 1'b1;
                  cnt_n   = CNT_LOAD;
                  state_n = LAUNCH;
               end else begin
                  state_n = IDLE;
               end
            end
`ifdef MUL_FEED_TIMEOUT_EN
            else if (tcnt_q == TMAX) begin
               // Give up on this product; queued pairs launch from IDLE.
               terr_n  = 1'b1;
               state_n = IDLE;
            end else begin
               tcnt_n = tcnt_q + TW'(1);
            end
`endif
         end
         default: begin
            state_n = IDLE;
            start_n = 1'b0;
         end
      endcase
   end

endmodule
